// File: rtl/lcd_pkg.sv
// Shared constants, state type and timing helpers for the character-LCD engine.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h30;
  localparam logic [7:0] FS_DL     = 8'h10;
  localparam logic [7:0] FS_N      = 8'h08;
  localparam logic [7:0] DISP_OFF  = 8'h08;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  typedef enum logic [2:0] {PWRUP, INIT, ROWADDR, CHARS, FRAME} eng_st_t;

  // ceil(ns*hz/1e9), never less than one cycle
  function automatic int ns2cyc(input longint ns, input longint hz);
    longint c;
    c = (ns * hz + 64'd999_999_999) / 64'd1_000_000_000;
    return (c < 1) ? 1 : int'(c);
  endfunction

  function automatic int us2cyc(input longint us, input longint hz);
    return ns2cyc(us * 1000, hz);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [6:0] row_base(input int row, input int cols);
    case (row)
      1:       return 7'h40;
      2:       return 7'(cols);
      3:       return 7'(64 + cols);
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD bus transfer: setup, E pulse, hold (twice in nibble mode), then post-wait.
module lcd_bus_cycle #(
  parameter int TW    = 16,
  parameter int SU_C  = 1,
  parameter int EH_C  = 1,
  parameter int GAP_C = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          rs,
  input  logic [7:0]    data,
  input  logic          nibble_mode,
  input  logic          single,
  input  logic          no_e,
  input  logic [TW-1:0] post_cycles,
  output logic          ready,
  output logic          done,
  output logic          lcd_rs,
  output logic          lcd_e,
  output logic [7:0]    lcd_db
);

  typedef enum logic [2:0] {B_IDLE, B_SETUP, B_EHI, B_HOLD, B_GAP, B_POST} bst_t;

  bst_t          st, st_n;
  logic [TW-1:0] tmr, tmr_n, post_q;
  logic [3:0]    lo_nib_q;
  logic          lo_q, lo_n, nib_q, single_q, last;

  assign ready = (st == B_IDLE);

  always_comb begin
    st_n  = st;
    lo_n  = lo_q;
    done  = 1'b0;
    last  = (tmr == '0);
    tmr_n = last ? '0 : tmr - TW'(1);
    case (st)
      B_IDLE: if (start) begin
        lo_n = 1'b0;
        if (no_e) begin st_n = B_POST;  tmr_n = post_cycles - TW'(1); end
        else      begin st_n = B_SETUP; tmr_n = TW'(SU_C - 1);        end
      end
      B_SETUP: if (last) begin st_n = B_EHI;  tmr_n = TW'(EH_C - 1); end
      B_EHI:   if (last) begin st_n = B_HOLD; tmr_n = TW'(SU_C - 1); end
      B_HOLD:  if (last) begin
        // high nibble of a pair gets the short gap, everything else the full post-wait
        if (nib_q && !lo_q && !single_q) begin st_n = B_GAP;  tmr_n = TW'(GAP_C - 1); end
        else                             begin st_n = B_POST; tmr_n = post_q - TW'(1); end
      end
      B_GAP:   if (last) begin st_n = B_SETUP; lo_n = 1'b1; tmr_n = TW'(SU_C - 1); end
      B_POST:  if (last) begin st_n = B_IDLE;  done = 1'b1; end
      default: st_n = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= B_IDLE;
      tmr      <= '0;
      post_q   <= '0;
      lo_nib_q <= '0;
      lo_q     <= 1'b0;
      nib_q    <= 1'b0;
      single_q <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_db   <= '0;
    end else begin
      st    <= st_n;
      tmr   <= tmr_n;
      lo_q  <= lo_n;
      lcd_e <= (st_n == B_EHI);
      if (st == B_IDLE && start) begin
        lo_nib_q <= data[3:0];
        post_q   <= post_cycles;
        nib_q    <= nibble_mode;
        single_q <= single;
        lcd_rs   <= rs;
        lcd_db   <= nibble_mode ? {data[7:4], 4'h0} : data;
      end else if (st == B_GAP && st_n == B_SETUP) begin
        lcd_db <= {lo_nib_q, 4'h0};
      end
    end
  end

endmodule

// File: rtl/lcd_text_engine.sv
// HD44780-class text engine: power-up wait, init sequence, then endless refresh of the text buffer.
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter  int CLK_HZ = 100_000_000,
  parameter  int ROWS   = 2,
  parameter  int COLS   = 16,
  parameter  int BUS4   = 0,
  parameter  int POR_US = 20000,
  parameter  int CMD_US = 50,
  parameter  int CLR_US = 2000,
  parameter  int E_NS   = 500,
  localparam int AW     = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          init_done,
  output logic          frame_pls,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_e,
  output logic [7:0]    lcd_db
);

  localparam int DEPTH = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(COLS);
  localparam int POR_C = us2cyc(POR_US, CLK_HZ);
  localparam int W1_C  = us2cyc(4100, CLK_HZ);
  localparam int W2_C  = us2cyc(100, CLK_HZ);
  localparam int CMD_C = us2cyc(CMD_US, CLK_HZ);
  localparam int CLR_C = us2cyc(CLR_US, CLK_HZ);
  localparam int GAP_C = us2cyc(1, CLK_HZ);
  localparam int SU_C  = ns2cyc(E_NS / 2, CLK_HZ);
  localparam int EH_C  = ns2cyc(E_NS, CLK_HZ);
  localparam int MAXC  = max2(max2(max2(POR_C, W1_C), max2(CLR_C, CMD_C)), max2(EH_C, W2_C));
  localparam int TW    = $clog2(MAXC + 1);
  localparam logic [7:0] FS_FINAL = ((BUS4 != 0) ? (FUNC_SET ^ FS_DL) : FUNC_SET) |
                                    ((ROWS > 1) ? FS_N : 8'h00);

  eng_st_t       st, st_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic [3:0]    init_idx, idx_n;
  logic          busy, done_q;
  logic          b_start, b_ready, b_done, b_rs, b_noe, b_single;
  logic [7:0]    b_data, init_byte, rd_q;
  logic [TW-1:0] b_post;
  logic [AW-1:0] rd_addr;
  int            init_wait;
  logic [7:0]    mem [DEPTH];

  assign lcd_rw  = 1'b0;
  assign rd_addr = AW'(int'(row) * COLS + int'(col));
  // the cycle after done is the fetch slot, so the next start sees fresh buffer data
  assign b_start = b_ready && !busy && !done_q && (st != FRAME);

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (done_q) rd_q <= mem[rd_addr];
  end

  // 8-bit mode skips step 3 (the lone 0x2 nibble that switches to 4-bit)
  always_comb begin
    init_wait = CMD_C;
    case (init_idx)
      4'd0:    begin init_byte = FUNC_SET; init_wait = W1_C; end
      4'd1:    begin init_byte = FUNC_SET; init_wait = W2_C; end
      4'd2:    init_byte = FUNC_SET;
      4'd3:    init_byte = FUNC_SET ^ FS_DL;
      4'd4:    init_byte = FS_FINAL;
      4'd5:    init_byte = DISP_OFF;
      4'd6:    begin init_byte = CLEAR; init_wait = CLR_C; end
      4'd7:    init_byte = ENTRY_INC;
      default: init_byte = DISP_ON;
    endcase
  end

  always_comb begin
    st_n     = st;
    row_n    = row;
    col_n    = col;
    idx_n    = init_idx;
    b_rs     = 1'b0;
    b_data   = 8'h00;
    b_noe    = 1'b0;
    b_single = 1'b0;
    b_post   = TW'(CMD_C);
    case (st)
      PWRUP: begin
        b_noe  = 1'b1;
        b_post = TW'(POR_C);
        if (b_done) begin st_n = INIT; idx_n = 4'd0; end
      end
      INIT: begin
        b_data   = init_byte;
        b_single = (BUS4 != 0) && (init_idx <= 4'd3);
        b_post   = TW'(init_wait);
        if (b_done) begin
          if (init_idx == 4'd8)                         begin st_n = ROWADDR; row_n = '0; end
          else if ((BUS4 == 0) && (init_idx == 4'd2))   idx_n = 4'd4;
          else                                          idx_n = init_idx + 4'd1;
        end
      end
      ROWADDR: begin
        b_data = SET_DDRAM | {1'b0, row_base(int'(row), COLS)};
        if (b_done) begin st_n = CHARS; col_n = '0; end
      end
      CHARS: begin
        b_rs   = 1'b1;
        b_data = rd_q;
        if (b_done) begin
          if (col == CW'(COLS - 1)) begin
            col_n = '0;
            if (row == RW'(ROWS - 1)) begin row_n = '0; st_n = FRAME; end
            else begin row_n = row + RW'(1); st_n = ROWADDR; end
          end else begin
            col_n = col + CW'(1);
          end
        end
      end
      FRAME:   st_n = ROWADDR;
      default: st_n = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= PWRUP;
      row       <= '0;
      col       <= '0;
      init_idx  <= '0;
      busy      <= 1'b0;
      done_q    <= 1'b0;
      init_done <= 1'b0;
      frame_pls <= 1'b0;
    end else begin
      st        <= st_n;
      row       <= row_n;
      col       <= col_n;
      init_idx  <= idx_n;
      done_q    <= b_done;
      frame_pls <= (st_n == FRAME);
      if (st_n == ROWADDR) init_done <= 1'b1;
      if (b_start)     busy <= 1'b1;
      else if (b_done) busy <= 1'b0;
    end
  end

  lcd_bus_cycle #(.TW(TW), .SU_C(SU_C), .EH_C(EH_C), .GAP_C(GAP_C)) u_bus (
    .clk         (clk),
    .rstn        (rstn),
    .start       (b_start),
    .rs          (b_rs),
    .data        (b_data),
    .nibble_mode (BUS4 != 0),
    .single      (b_single),
    .no_e        (b_noe),
    .post_cycles (b_post),
    .ready       (b_ready),
    .done        (b_done),
    .lcd_rs      (lcd_rs),
    .lcd_e       (lcd_e),
    .lcd_db      (lcd_db)
  );

endmodule

// File: tb/tb_lcd_text_engine.sv
// Bench: three engines (2x16 8-bit, 4x20 8-bit, 2x16 4-bit); bytes captured on each E rise vs tables.
module tb_lcd_text_engine;

  typedef struct {
    string      nm;
    logic [8:0] exp;   // {rs, db}
  } vec_t;

  logic       clk, rstn0, rstn;
  logic       wr_en0, wr_en1, wr_en2;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] wr_addr1;
  logic [7:0] wr_data1;

  logic       d0_idone, d0_fp, d0_rs, d0_rw, d0_e;  logic [7:0] d0_db;
  logic       d1_idone, d1_fp, d1_rs, d1_rw, d1_e;  logic [7:0] d1_db;
  logic       d2_idone, d2_fp, d2_rs, d2_rw, d2_e;  logic [7:0] d2_db;

  int n_chk = 0, n_fail = 0;
  logic [9:0] q0[$], q1[$], q2[$];
  vec_t t0[$], t1[$], t2[$];
  logic e0p = 0, e1p = 0, e2p = 0, lo_nz = 0;
  int fp0 = 0, fp0_at = -1;

  initial clk = 0;
  always #5 clk = ~clk;

  lcd_text_engine #(.CLK_HZ(1_000_000), .ROWS(2), .COLS(16), .BUS4(0), .POR_US(20),
                    .CMD_US(5), .CLR_US(30), .E_NS(2000)) u0 (
    .clk(clk), .rstn(rstn0), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(d0_idone), .frame_pls(d0_fp), .lcd_rs(d0_rs), .lcd_rw(d0_rw), .lcd_e(d0_e), .lcd_db(d0_db));

  lcd_text_engine #(.CLK_HZ(1_000_000), .ROWS(4), .COLS(20), .BUS4(0), .POR_US(20),
                    .CMD_US(5), .CLR_US(30), .E_NS(2000)) u1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .init_done(d1_idone), .frame_pls(d1_fp), .lcd_rs(d1_rs), .lcd_rw(d1_rw), .lcd_e(d1_e), .lcd_db(d1_db));

  lcd_text_engine #(.CLK_HZ(1_000_000), .ROWS(2), .COLS(16), .BUS4(1), .POR_US(20),
                    .CMD_US(5), .CLR_US(30), .E_NS(2000)) u2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(d2_idone), .frame_pls(d2_fp), .lcd_rs(d2_rs), .lcd_rw(d2_rw), .lcd_e(d2_e), .lcd_db(d2_db));

  always @(negedge clk) begin
    if (d0_e && !e0p) begin
      q0.push_back({d0_idone, d0_rs, d0_db});
      if (q0.size() == 76) fp0_at = fp0;
    end
    if (d1_e && !e1p) q1.push_back({d1_idone, d1_rs, d1_db});
    if (d2_e && !e2p) q2.push_back({d2_idone, d2_rs, d2_db});
    e0p = d0_e; e1p = d1_e; e2p = d2_e;
    if (d0_fp) fp0++;
    if (d2_db[3:0] != 4'h0) lo_nz = 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic add(input int which, input string nm, input logic rs, input logic [7:0] db);
    vec_t v;
    v.nm = nm; v.exp = {rs, db};
    if (which == 0) t0.push_back(v);
    else if (which == 1) t1.push_back(v);
    else t2.push_back(v);
  endtask

  task automatic cmp_tab(input int which, input int n);
    logic [31:0] got;
    vec_t v;
    for (int i = 0; i < n; i++) begin
      got = 32'hDEAD;
      if (which == 0) begin v = t0[i]; if (i < q0.size()) got = 32'(q0[i][8:0]); end
      else if (which == 1) begin v = t1[i]; if (i < q1.size()) got = 32'(q1[i][8:0]); end
      else begin v = t2[i]; if (i < q2.size()) got = 32'(q2[i][8:0]); end
      chk(v.nm, got, 32'(v.exp));
    end
  endtask

  initial begin
    logic [7:0] ib[8];
    logic [3:0] nb[14];
    logic [7:0] rb[4];
    logic [7:0] ch;
    bit early, ok, z_done;

    ib = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    nb = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
    rb = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    // expected streams
    for (int i = 0; i < 8; i++) begin
      add(0, $sformatf("u0_init%0d", i), 1'b0, ib[i]);
      add(1, $sformatf("u1_init%0d", i), 1'b0, ib[i]);
    end
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 2; r++) begin
        add(0, $sformatf("u0_p%0d_rowaddr%0d", p, r), 1'b0, rb[r]);
        for (int c = 0; c < 16; c++) begin
          ch = (r == 0) ? 8'(8'h41 + c) : 8'(8'h61 + c);
          if (p == 1 && r == 0 && c == 5) ch = 8'h5A;
          add(0, $sformatf("u0_p%0d_r%0d_c%0d", p, r, c), 1'b1, ch);
        end
      end
    for (int r = 0; r < 4; r++) begin
      add(1, $sformatf("u1_rowaddr%0d", r), 1'b0, rb[r]);
      for (int c = 0; c < 20; c++) add(1, $sformatf("u1_r%0d_c%0d", r, c), 1'b1, 8'(8'h21 + r * 20 + c));
    end
    for (int i = 0; i < 14; i++) add(2, $sformatf("u2_init_nib%0d", i), 1'b0, {nb[i], 4'h0});
    add(2, "u2_rowaddr_hi", 1'b0, 8'h80);
    add(2, "u2_rowaddr_lo", 1'b0, 8'h00);
    for (int c = 0; c < 16; c++) begin
      ch = 8'(8'h41 + c);
      add(2, $sformatf("u2_c%0d_hi", c), 1'b1, {ch[7:4], 4'h0});
      add(2, $sformatf("u2_c%0d_lo", c), 1'b1, {ch[3:0], 4'h0});
    end

    rstn0 = 0; rstn = 0;
    wr_en0 = 0; wr_en1 = 0; wr_en2 = 0;
    wr_addr = '0; wr_data = '0; wr_addr1 = '0; wr_data1 = '0;
    z_done = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({d0_idone, d0_fp, d0_rs, d0_rw, d0_e, d0_db}), 32'h0);

    // release and preload buffers during power-up; addr 100 on the 4x20 unit is out of range
    rstn0 = 1; rstn = 1;
    early = 0;
    for (int i = 0; i < 81; i++) begin
      if (i < 20 && d0_e) early = 1;
      wr_en0 = (i < 32); wr_en2 = (i < 32);
      wr_addr = 5'(i);
      wr_data = (i < 16) ? 8'(8'h41 + i) : 8'(8'h61 + i - 16);
      wr_en1 = 1;
      wr_addr1 = (i < 80) ? 7'(i) : 7'd100;
      wr_data1 = (i < 80) ? 8'(8'h21 + i) : 8'h23;
      @(negedge clk);
    end
    wr_en0 = 0; wr_en1 = 0; wr_en2 = 0;
    chk("no_e_during_por", 32'(early), 32'h0);

    // run two passes on u0; overwrite addr 5 while the old char 5 is on the bus
    ok = 0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge clk);
      wr_en0 = 0;
      if (!z_done && d0_e && d0_rs && d0_db == 8'h46) begin
        wr_en0 = 1; wr_addr = 5'd5; wr_data = 8'h5A; z_done = 1;
      end
      ok = (q0.size() >= 76) && (q1.size() >= 92) && (q2.size() >= 48);
    end
    wr_en0 = 0;
    chk("capture_wait", 32'(ok), 32'h1);
    chk("z_written", 32'(z_done), 32'h1);

    cmp_tab(0, 76);
    cmp_tab(1, 92);
    cmp_tab(2, 48);
    chk("u0_idone_at_0x0C", (q0.size() > 8) ? 32'(q0[7][9]) : 32'hDEAD, 32'h0);
    chk("u0_idone_at_0x80", (q0.size() > 8) ? 32'(q0[8][9]) : 32'hDEAD, 32'h1);
    chk("u0_frame_pulse_cycles", 32'(fp0_at), 32'h1);
    chk("u2_db_low_nibble_zero", 32'(lo_nz), 32'h0);
    chk("u0_rw_tied_low", 32'(d0_rw), 32'h0);

    // async reset with E high during a character
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (d0_e && d0_rs) ok = 1;
    end
    chk("wait_e_in_chars", 32'(ok), 32'h1);
    #1 rstn0 = 0;
    #1;
    chk("rst_mid_e", 32'(d0_e), 32'h0);
    chk("rst_mid_rs", 32'(d0_rs), 32'h0);
    chk("rst_mid_db", 32'(d0_db), 32'h0);
    chk("rst_mid_idone", 32'(d0_idone), 32'h0);
    q0.delete();
    repeat (3) @(negedge clk);
    rstn0 = 1;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      if (d0_e) early = 1;
      @(negedge clk);
    end
    chk("no_e_after_rerelease", 32'(early), 32'h0);
    ok = 0;
    for (int c = 0; c < 8000 && !ok; c++) begin
      @(negedge clk);
      ok = (q0.size() >= 9);
    end
    chk("replay_wait", 32'(ok), 32'h1);
    cmp_tab(0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
